// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: op encodings, FSM states, defaults.
package branch_pkg;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_BEQ  = 2'b01;
    localparam logic [1:0] OP_BNE  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam int unsigned DEF_FLUSH_CYCLES = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    // Reserved and none ops are never taken.
    function automatic logic branch_taken(input logic [1:0] op, input logic zero);
        logic taken;
        case (op)
            OP_BEQ:  taken = zero;
            OP_BNE:  taken = !zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/branch_target_adder.sv
// Branch target: pc_plus4 plus the word offset scaled to bytes, wrapping modulo 2^32.
module branch_target_adder (
    input  logic [31:0] i_pc_plus4,
    input  logic [31:0] i_imm,
    output logic [31:0] o_target
);

    logic [31:0] w_imm_shl;

    assign w_imm_shl = i_imm << 2;
    assign o_target  = i_pc_plus4 + w_imm_shl;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: registers the ALU result, decides taken, redirects the PC
// and holds a younger-stage flush for FLUSH_CYCLES cycles after each taken branch.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_pc_plus4,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_zero,
    output logic             out_taken,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [2:0]       FLUSH_LAST = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e            r_state;
    state_e            w_state_d;
    logic [2:0]        r_flush_cnt;
    logic [2:0]        w_flush_cnt_d;
    logic              r_out_valid;
    logic [31:0]       r_out_result;
    logic              r_out_zero;
    logic              r_out_taken;
    logic              r_redirect_valid;
    logic [31:0]       r_redirect_pc;
    logic [CNT_W-1:0]  r_taken_count;

    logic              w_zero;
    logic              w_taken;
    logic              w_in_xfer;
    logic              w_br_xfer;
    logic [31:0]       w_target;

    assign w_zero    = (in_result == 32'd0);
    assign w_taken   = branch_taken(in_op, w_zero);
    assign in_ready  = (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_in_xfer = in_valid && in_ready;
    assign w_br_xfer = w_in_xfer && w_taken;

    branch_target_adder u_target_adder (
        .i_pc_plus4 (in_pc_plus4),
        .i_imm      (in_imm),
        .o_target   (w_target)
    );

    always_comb begin
        w_state_d     = r_state;
        w_flush_cnt_d = r_flush_cnt;
        case (r_state)
            IDLE: begin
                if (w_br_xfer) begin
                    w_state_d     = FLUSH;
                    w_flush_cnt_d = 3'd0;
                end
            end
            FLUSH: begin
                if (r_flush_cnt == FLUSH_LAST) begin
                    w_state_d     = IDLE;
                    w_flush_cnt_d = 3'd0;
                end else begin
                    w_flush_cnt_d = r_flush_cnt + 3'd1;
                end
            end
            default: begin
                w_state_d     = IDLE;
                w_flush_cnt_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_flush_cnt      <= 3'd0;
            r_out_valid      <= 1'b0;
            r_out_result     <= 32'd0;
            r_out_zero       <= 1'b0;
            r_out_taken      <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_taken_count    <= '0;
        end else begin
            r_state          <= w_state_d;
            r_flush_cnt      <= w_flush_cnt_d;
            r_redirect_valid <= w_br_xfer;
            if (w_in_xfer) begin
                r_out_valid  <= 1'b1;
                r_out_result <= in_result;
                r_out_zero   <= w_zero;
                r_out_taken  <= w_taken;
            end else if (out_ready) begin
                r_out_valid  <= 1'b0;
            end
            if (w_br_xfer) begin
                r_redirect_pc <= w_target;
            end
            // Saturate rather than wrap so software sees a ceiling, not a reset.
            if (w_br_xfer && (r_taken_count != CNT_MAX)) begin
                r_taken_count <= r_taken_count + CNT_ONE;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_result     = r_out_result;
    assign out_zero       = r_out_zero;
    assign out_taken      = r_out_taken;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush          = (r_state == FLUSH);
    assign taken_count    = r_taken_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a cycle model and an output scoreboard.
module tb_branch_resolve_unit;

    localparam int unsigned TB_FLUSH = 2;
    localparam int unsigned TB_CNT_W = 4;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        taken;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_result;
    logic [1:0]          in_op;
    logic [31:0]         in_pc_plus4;
    logic [31:0]         in_imm;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_result;
    logic                out_zero;
    logic                out_taken;
    logic                redirect_valid;
    logic [31:0]         redirect_pc;
    logic                flush;
    logic [TB_CNT_W-1:0] taken_count;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model state: what the DUT must show at the next falling edge.
    logic                m_ov  = 1'b0;
    logic                m_rv  = 1'b0;
    logic [31:0]         m_rpc = 32'd0;
    int                  m_fl  = 0;
    logic [TB_CNT_W-1:0] m_cnt = '0;
    exp_t                q[$];

    branch_resolve_unit #(
        .FLUSH_CYCLES (TB_FLUSH),
        .CNT_W        (TB_CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_result      (in_result),
        .in_op          (in_op),
        .in_pc_plus4    (in_pc_plus4),
        .in_imm         (in_imm),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_zero       (out_zero),
        .out_taken      (out_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .taken_count    (taken_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_taken(input logic [1:0] op, input logic [31:0] res);
        return ((op == 2'b01) && (res == 32'd0)) || ((op == 2'b10) && (res != 32'd0));
    endfunction

    always @(negedge clk) begin
        logic rdy;
        logic xfer;
        logic tk;
        exp_t e;
        rdy = (m_fl == 0) && (!m_ov || out_ready);
        if (chk_en) begin
            chk("m_in_ready", 32'(in_ready), 32'(rdy));
            chk("m_out_valid", 32'(out_valid), 32'(m_ov));
            chk("m_redirect_valid", 32'(redirect_valid), 32'(m_rv));
            if (m_rv) chk("m_redirect_pc", redirect_pc, m_rpc);
            chk("m_flush", 32'(flush), 32'(m_fl != 0));
            chk("m_taken_count", 32'(taken_count), 32'(m_cnt));
            if (m_ov && (q.size() > 0)) begin
                e = q[0];
                chk("sb_out_result", out_result, e.res);
                chk("sb_out_zero", 32'(out_zero), 32'(e.zero));
                chk("sb_out_taken", 32'(out_taken), 32'(e.taken));
            end
        end
        if (!rst_n) begin
            m_ov  = 1'b0;
            m_rv  = 1'b0;
            m_rpc = 32'd0;
            m_fl  = 0;
            m_cnt = '0;
            q.delete();
        end else begin
            xfer = in_valid && rdy;
            tk   = model_taken(in_op, in_result);
            if (m_ov && out_ready && (q.size() > 0)) void'(q.pop_front());
            if (xfer) begin
                e.res   = in_result;
                e.zero  = (in_result == 32'd0);
                e.taken = tk;
                q.push_back(e);
                m_ov = 1'b1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            m_rv = xfer && tk;
            if (xfer && tk) m_rpc = in_pc_plus4 + (in_imm << 2);
            if (m_fl > 0) m_fl = m_fl - 1;
            else if (xfer && tk) m_fl = TB_FLUSH;
            if (xfer && tk && (m_cnt != '1)) m_cnt = m_cnt + 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] res,
                         input logic [31:0] pc, input logic [31:0] imm);
        in_valid    = 1'b1;
        in_op       = op;
        in_result   = res;
        in_pc_plus4 = pc;
        in_imm      = imm;
    endtask

    // Offer a taken BEQ and wait (bounded) until it is accepted.
    task automatic send_taken(input int idx);
        int n;
        n = 0;
        tick();
        drive(2'b01, 32'd0, 32'(idx) << 4, 32'(idx));
        @(negedge clk);
        while (!in_ready && (n < 10)) begin
            @(negedge clk);
            n++;
        end
        chk("sat_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_op       = 2'b00;
        in_result   = 32'd0;
        in_pc_plus4 = 32'd0;
        in_imm      = 32'd0;
        out_ready   = 1'b1;
        repeat (2) tick();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        chk("rst_out_taken", 32'(out_taken), 32'd0);
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_taken_count", 32'(taken_count), 32'd0);
        tick();
        rst_n = 1'b1;

        // BEQ taken with zero result
        drive(2'b01, 32'h0000_0000, 32'h0040_0010, 32'h0000_0004);
        @(negedge clk);
        chk("beq_in_ready_pre", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("beq_out_valid", 32'(out_valid), 32'd1);
        chk("beq_out_zero", 32'(out_zero), 32'd1);
        chk("beq_out_taken", 32'(out_taken), 32'd1);
        chk("beq_redirect_valid", 32'(redirect_valid), 32'd1);
        chk("beq_redirect_pc", redirect_pc, 32'h0040_0020);
        chk("beq_flush_c1", 32'(flush), 32'd1);
        chk("beq_in_ready_c1", 32'(in_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("beq_flush_c2", 32'(flush), 32'd1);
        chk("beq_in_ready_c2", 32'(in_ready), 32'd0);
        chk("beq_redirect_pulse", 32'(redirect_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("beq_flush_end", 32'(flush), 32'd0);
        chk("beq_in_ready_end", 32'(in_ready), 32'd1);

        // BNE taken on nonzero, then BEQ not taken on the same result
        tick();
        drive(2'b10, 32'h8000_0000, 32'h0000_1000, 32'h0000_0010);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bne_out_zero", 32'(out_zero), 32'd0);
        chk("bne_out_taken", 32'(out_taken), 32'd1);
        chk("bne_out_result", out_result, 32'h8000_0000);
        chk("bne_flush", 32'(flush), 32'd1);
        repeat (2) tick();
        drive(2'b01, 32'h8000_0000, 32'h0000_2000, 32'h0000_0008);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("beqnt_out_taken", 32'(out_taken), 32'd0);
        chk("beqnt_out_zero", 32'(out_zero), 32'd0);
        chk("beqnt_flush", 32'(flush), 32'd0);
        chk("beqnt_redirect", 32'(redirect_valid), 32'd0);
        chk("beqnt_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back non-branch inputs under a 3-cycle output stall
        tick();
        out_ready = 1'b0;
        drive(2'b00, 32'h1111_1111, 32'h0, 32'h0);
        tick();
        drive(2'b11, 32'h0000_0000, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_out_result", out_result, 32'h1111_1111);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("nobubble_out_valid", 32'(out_valid), 32'd1);
        chk("nobubble_out_result", out_result, 32'h0000_0000);
        chk("rsvd_out_taken", 32'(out_taken), 32'd0);
        chk("rsvd_flush", 32'(flush), 32'd0);
        tick();
        @(negedge clk);
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // Target wrap-around
        tick();
        drive(2'b01, 32'd0, 32'hFFFF_FFFC, 32'h0000_0001);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("wrap_pc_zero", redirect_pc, 32'h0000_0000);
        repeat (2) tick();
        drive(2'b01, 32'd0, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("wrap_pc_neg", redirect_pc, 32'hFFFF_FFF8);
        repeat (2) tick();
        @(negedge clk);
        chk("count_four", 32'(taken_count), 32'd4);

        // Reset during the second flush cycle
        tick();
        drive(2'b10, 32'd5, 32'h0000_0100, 32'h0000_0001);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_flush_c1", 32'(flush), 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("rstmid_flush", 32'(flush), 32'd0);
        chk("rstmid_out_valid", 32'(out_valid), 32'd0);
        chk("rstmid_count", 32'(taken_count), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_in_ready", 32'(in_ready), 32'd1);

        // Counter saturation with a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            send_taken(i);
            if (i == 13) begin
                @(negedge clk);
                chk("sat_count_14", 32'(taken_count), 32'd14);
            end
        end
        @(negedge clk);
        chk("sat_count_max", 32'(taken_count), 32'h0000_000F);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 2, number of cycles the younger-stage flush is held after a taken branch (legal 1..7).
REQ-002 Parameter: CNT_W, default 16, width of the taken-branch counter.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port: in_valid  input  1  EX-stage result valid.
REQ-006 Port: in_ready  output  1  block accepts input this cycle.
REQ-007 Port: in_result  input  32  ALU result; zero when operands equal.
REQ-008 Port: in_op  input  2  branch op: 00 none, 01 BEQ, 10 BNE, 11 reserved (treated as none).
REQ-009 Port: in_pc_plus4  input  32  PC+4 of the branch instruction.
REQ-010 Port: in_imm  input  32  sign-extended word offset.
REQ-011 Port: out_valid  output  1  registered result valid.
REQ-012 Port: out_ready  input  1  downstream accepts the output.
REQ-013 Port: out_result  output  32  registered in_result.
REQ-014 Port: out_zero  output  1  registered zero flag of in_result.
REQ-015 Port: out_taken  output  1  branch taken.
REQ-016 Port: redirect_valid  output  1  one-cycle PC redirect pulse.
REQ-017 Port: redirect_pc  output  32  branch target.
REQ-018 Port: flush  output  1  kill younger pipeline stages.
REQ-019 Port: taken_count  output  CNT_W  saturating count of taken branches.

Function
REQ-020 Transfer in occurs when in_valid and in_ready are both high at a rising edge; output transfer occurs when out_valid and out_ready are both high.
REQ-021 in_ready SHALL equal (state == IDLE) and (!out_valid or out_ready).
REQ-022 Zero flag = 1 iff all 32 bits of in_result are 0; captured with in_result at transfer, one-cycle latency to out_zero.
REQ-023 Taken = (op==BEQ and zero) or (op==BNE and !zero); ops 00 and 11 are never taken.
REQ-024 Target = in_pc_plus4 + (in_imm << 2), modulo 2^32 (wrap, no overflow flag).
REQ-025 out_* registers hold their values, stable, while out_valid=1 and out_ready=0.
REQ-026 Simultaneous output transfer and input transfer in the same cycle: out_valid stays 1 and the new data is loaded (no bubble).
REQ-027 Output transfer with no input transfer clears out_valid next cycle.
REQ-028 FSM states: IDLE, FLUSH. IDLE -> FLUSH on transfer of a taken branch; FLUSH -> IDLE when flush counter reaches FLUSH_CYCLES-1.
REQ-029 redirect_valid SHALL pulse high exactly one cycle, the cycle after the taken transfer, with redirect_pc = target; it is independent of out_ready.
REQ-030 flush SHALL be high for exactly FLUSH_CYCLES consecutive cycles starting the cycle after the taken transfer; in_ready is low throughout.
REQ-031 taken_count increments by 1 on each taken transfer; saturates at 2^CNT_W-1 (no wrap).
REQ-032 Not-taken transfers leave FSM in IDLE, redirect_valid and flush low.

Reset
REQ-033 rst_n low at a rising edge SHALL force: state IDLE, flush counter 0, out_valid 0, out_result 0, out_zero 0, out_taken 0, redirect_valid 0, redirect_pc 0, flush 0, taken_count 0.
REQ-034 Reset mid-FLUSH aborts flush immediately (flush low the cycle after reset edge); in_ready high the first cycle after rst_n returns high.

Structure
REQ-035 Shared package branch_pkg holds op encodings (OP_NONE, OP_BEQ, OP_BNE, OP_RSVD), FSM state typedef, and FLUSH_CYCLES default.
REQ-036 One sub-module, branch_target_adder (32-bit pc_plus4 + shifted imm, combinational); zero detection and FSM stay in the top.

Verification
REQ-037 BEQ, in_result=0x00000000, pc_plus4=0x00400010, imm=0x00000004, out_ready=1 -> next cycle out_zero=1, out_taken=1, redirect_valid=1, redirect_pc=0x00400020; flush high 2 cycles; in_ready low 2 cycles.
REQ-038 BNE, in_result=0x80000000 -> out_zero=0, out_taken=1; BEQ, same result -> out_taken=0, no flush, in_ready stays 1.
REQ-039 Back-to-back non-branch inputs, out_ready=0 for 3 cycles -> first output held stable, in_ready=0, second accepted the cycle out_ready rises, no bubble.
REQ-040 pc_plus4=0xFFFFFFFC, imm=0x00000001, BEQ taken -> redirect_pc=0x00000000; imm=0xFFFFFFFF -> redirect_pc=0xFFFFFFF8.
REQ-041 rst_n low during 2nd flush cycle -> flush=0, out_valid=0, taken_count=0 next cycle; in_ready=1 after release.
REQ-042 CNT_W=4, 17 taken branches -> taken_count saturates at 0xF.
